// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the fetch-stage program-counter unit.
//   - PC_SEL_W : width of the next-PC select bus
//   - pc_sel_e : encoding of the next-PC select (110/111 are unused and act as hold)
package pc_seq_pkg;

  localparam int unsigned PC_SEL_W = 3;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_HOLD   = 3'b000,
    PC_SEQ    = 3'b001,
    PC_JUMP   = 3'b010,
    PC_BRANCH = 3'b011,
    PC_CALL   = 3'b100,
    PC_RET    = 3'b101
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
// A push writes at the pointer and advances it.  When the stack is full the
// write lands on the oldest entry, so the count saturates at RAS_DEPTH.
// A pop on an empty stack is ignored.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, pop    : stack operations (never both in one cycle)
//   push_data    : value pushed
//   top_data     : most recently pushed valid entry
//   count        : number of valid entries (0..RAS_DEPTH)
//   full, empty  : count == RAS_DEPTH / count == 0
module ras_stack #(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned RAS_DEPTH = 4,
  localparam int unsigned CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;
  logic [CNT_W-1:0] count_q, count_d;

  // ptr_q is the next write slot; the top entry sits one slot below it.
  // Explicit wrap keeps non-power-of-two depths correct.
  assign ptr_inc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec  = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);
  assign top_data = mem_q[ptr_dec];
  assign full     = (count_q == CNT_MAX);
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_inc;
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d   = ptr_dec;
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; invalid entries are never read as meaningful data.
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with return-address stack.
// Selects the next PC from hold / sequential / jump / branch / call / return,
// forces redirect targets onto an aligned boundary and flags the fix-up.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   stall         : freeze PC and RAS for this cycle, misalign reads 0
//   pc_sel        : next-PC select (pc_sel_e)
//   target        : absolute address for jump and call
//   offset        : two's-complement branch offset
//   pc            : current PC (registered)
//   pc_inc        : pc + INC (combinational)
//   ras_count     : valid RAS entries
//   ras_overflow  : sticky, call with RAS full
//   ras_underflow : sticky, return with RAS empty
//   misalign      : one-cycle pulse after a misaligned redirect
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter  int unsigned      WIDTH        = 32,
  parameter  logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter  int unsigned      INC          = 4,
  parameter  int unsigned      RAS_DEPTH    = 4,
  parameter  int unsigned      ALIGN_BITS   = 2,
  localparam int unsigned      CNT_W        = $clog2(RAS_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic [PC_SEL_W-1:0] pc_sel,
  input  logic [WIDTH-1:0]    target,
  input  logic [WIDTH-1:0]    offset,
  output logic [WIDTH-1:0]    pc,
  output logic [WIDTH-1:0]    pc_inc,
  output logic [CNT_W-1:0]    ras_count,
  output logic                ras_overflow,
  output logic                ras_underflow,
  output logic                misalign
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mis_q, mis_d;
  logic             redirect;
  logic [WIDTH-1:0] redirect_addr;
  logic             push, pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_full, ras_empty;

  assign sel    = pc_sel_e'(pc_sel);
  assign pc_inc = pc_q + WIDTH'(INC);

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    pc_d          = pc_q;
    mis_d         = 1'b0;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    push          = 1'b0;
    pop           = 1'b0;
    redirect      = 1'b0;
    redirect_addr = target;
    if (!stall) begin
      unique case (sel)
        PC_SEQ: pc_d = pc_inc;
        PC_JUMP: redirect = 1'b1;
        PC_BRANCH: begin
          redirect      = 1'b1;
          redirect_addr = pc_q + offset;
        end
        PC_CALL: begin
          redirect = 1'b1;
          push     = 1'b1;
          if (ras_full) ovf_d = 1'b1;
        end
        PC_RET: begin
          // A return with nothing on the stack leaves the PC where it is.
          if (ras_empty) begin
            unf_d = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default: ;  // hold, including the unused encodings
      endcase
    end
    // Redirect targets are snapped down to the alignment boundary; the
    // dropped bits are reported one cycle later through misalign.
    if (redirect) begin
      pc_d  = redirect_addr & ~ALIGN_MASK;
      mis_d = |(redirect_addr & ALIGN_MASK);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mis_q <= mis_d;
    end
  end

  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign misalign      = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  pc_sel;
  logic [31:0] target;
  logic [31:0] offset;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misalign;

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .pc_sel        (pc_sel),
    .target        (target),
    .offset        (offset),
    .pc            (pc),
    .pc_inc        (pc_inc),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .misalign      (misalign)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: PC as a plain number, RAS as a queue of return addresses
  // (newest at the back, oldest dropped from the front when capacity is exceeded).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_ovf, m_unf, m_mis;

  task automatic model_step(input logic r, input logic s, input logic [2:0] sel,
                            input logic [31:0] t, input logic [31:0] o);
    logic [31:0] a;
    if (r) begin
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 0;
      m_unf = 0;
      m_mis = 0;
      return;
    end
    m_mis = 0;
    if (s) return;
    case (sel)
      PC_SEQ: m_pc = m_pc + 32'd4;
      PC_JUMP, PC_BRANCH, PC_CALL: begin
        a = (sel == PC_BRANCH) ? m_pc + o : t;
        if (sel == PC_CALL) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) begin
            m_ovf = 1;
            void'(m_ras.pop_front());
          end
        end
        m_mis = (a % 4) != 0;
        m_pc  = a - (a % 4);
      end
      PC_RET: begin
        if (m_ras.size() == 0) m_unf = 1;
        else m_pc = m_ras.pop_back();
      end
      default: ;
    endcase
  endtask

  task automatic compare_model(input string tag);
    check({tag, " pc"},        pc,                    m_pc);
    check({tag, " pc_inc"},    pc_inc,                m_pc + 32'd4);
    check({tag, " ras_count"}, 32'(ras_count),        32'(m_ras.size()));
    check({tag, " overflow"},  32'(ras_overflow),     32'(m_ovf));
    check({tag, " underflow"}, 32'(ras_underflow),    32'(m_unf));
    check({tag, " misalign"},  32'(misalign),         32'(m_mis));
  endtask

  task automatic drive_cycle(input string tag, input logic r, input logic s, input logic [2:0] sel,
                             input logic [31:0] t, input logic [31:0] o);
    reset  = r;
    stall  = s;
    pc_sel = sel;
    target = t;
    offset = o;
    model_step(r, s, sel, t, o);
    @(posedge clock);
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    logic        stall;
    logic [2:0]  sel;
    logic [31:0] tgt;
    logic [31:0] off;
    logic [31:0] exp_pc;
    int          exp_cnt;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, input logic [2:0] sel, input logic [31:0] t,
                         input logic [31:0] o, input logic [31:0] epc, input int ecnt,
                         input logic emis);
    vec_t v;
    v.stall = s; v.sel = sel; v.tgt = t; v.off = o;
    v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_mis = emis;
    vecs.push_back(v);
  endtask

  initial begin
    // Directed table: expectations derived by hand from the operation rules.
    add_vec(0, PC_SEQ,    32'h0,   32'h0,         32'h004, 0, 0);
    add_vec(0, PC_SEQ,    32'h0,   32'h0,         32'h008, 0, 0);
    add_vec(0, PC_SEQ,    32'h0,   32'h0,         32'h00C, 0, 0);
    add_vec(0, PC_SEQ,    32'h0,   32'h0,         32'h010, 0, 0);
    add_vec(0, PC_BRANCH, 32'h0,   32'hFFFF_FFF8, 32'h008, 0, 0);
    add_vec(0, PC_JUMP,   32'h103, 32'h0,         32'h100, 0, 1);
    add_vec(0, PC_HOLD,   32'h0,   32'h0,         32'h100, 0, 0);
    add_vec(0, PC_JUMP,   32'h040, 32'h0,         32'h040, 0, 0);
    add_vec(0, PC_CALL,   32'h200, 32'h0,         32'h200, 1, 0);
    add_vec(0, PC_CALL,   32'h300, 32'h0,         32'h300, 2, 0);
    add_vec(0, PC_RET,    32'h0,   32'h0,         32'h204, 1, 0);
    add_vec(0, PC_RET,    32'h0,   32'h0,         32'h044, 0, 0);
    add_vec(0, 3'b110,    32'h8,   32'h8,         32'h044, 0, 0);
    add_vec(0, 3'b111,    32'h8,   32'h8,         32'h044, 0, 0);
    add_vec(1, PC_CALL,   32'h080, 32'h0,         32'h044, 0, 0);
    add_vec(1, PC_CALL,   32'h080, 32'h0,         32'h044, 0, 0);
    add_vec(0, PC_CALL,   32'h080, 32'h0,         32'h080, 1, 0);
    add_vec(0, PC_RET,    32'h0,   32'h0,         32'h048, 0, 0);
    add_vec(0, PC_BRANCH, 32'h0,   32'h2,         32'h048, 0, 1);
    add_vec(1, PC_JUMP,   32'h101, 32'h0,         32'h048, 0, 0);

    // Reset state.
    drive_cycle("reset", 1, 0, PC_HOLD, 32'h0, 32'h0);
    check("reset pc",        pc,                 32'h0);
    check("reset ras_count", 32'(ras_count),     32'h0);
    check("reset flags",     32'({ras_overflow, ras_underflow, misalign}), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle($sformatf("vec%0d", i), 0, vecs[i].stall, vecs[i].sel, vecs[i].tgt, vecs[i].off);
      check($sformatf("vec%0d exp pc", i),  pc,               vecs[i].exp_pc);
      check($sformatf("vec%0d exp cnt", i), 32'(ras_count),   32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d exp mis", i), 32'(misalign),    32'(vecs[i].exp_mis));
    end

    // Overflow: five calls, each to the next pc + 0x10, then five returns.
    drive_cycle("ovf reset", 1, 0, PC_HOLD, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive_cycle($sformatf("ovf call%0d", k), 0, 0, PC_CALL, 32'(32'h10 * (k + 1)), 32'h0);
      check($sformatf("ovf call%0d exp pc", k), pc, 32'(32'h10 * (k + 1)));
    end
    check("ovf flag",  32'(ras_overflow), 32'h1);
    check("ovf count", 32'(ras_count),    32'h4);
    for (int k = 0; k < 4; k++) begin
      drive_cycle($sformatf("ovf ret%0d", k), 0, 0, PC_RET, 32'h0, 32'h0);
      check($sformatf("ovf ret%0d exp pc", k), pc, 32'(32'h44 - 32'h10 * k));
    end
    drive_cycle("unf ret", 0, 0, PC_RET, 32'h0, 32'h0);
    check("unf exp pc",    pc,                  32'h14);
    check("unf exp flag",  32'(ras_underflow),  32'h1);
    check("unf exp count", 32'(ras_count),      32'h0);

    // Wrap-around.
    drive_cycle("wrap jump", 0, 0, PC_JUMP, 32'hFFFF_FFFC, 32'h0);
    check("wrap pc_inc", pc_inc, 32'h0);
    drive_cycle("wrap seq", 0, 0, PC_SEQ, 32'h0, 32'h0);
    check("wrap pc", pc, 32'h0);

    // Reset beats stall and call, with flags and a pulse pending.
    drive_cycle("prio call", 0, 0, PC_CALL, 32'h103, 32'h0);
    check("prio pre mis", 32'(misalign), 32'h1);
    drive_cycle("prio reset", 1, 1, PC_CALL, 32'h555, 32'h0);
    check("prio pc",    pc,             32'h0);
    check("prio count", 32'(ras_count), 32'h0);
    check("prio flags", 32'({ras_overflow, ras_underflow, misalign}), 32'h0);
    drive_cycle("prio after", 0, 0, PC_HOLD, 32'h0, 32'h0);
    check("prio after mis", 32'(misalign), 32'h0);

    // Randomized traffic against the model.
    drive_cycle("rnd reset", 1, 0, PC_HOLD, 32'h0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      logic        r, s;
      logic [2:0]  sel;
      logic [31:0] t, o;
      r   = ($urandom_range(99) == 0);
      s   = ($urandom_range(99) < 15);
      sel = 3'($urandom_range(7));
      t   = $urandom;
      if ($urandom_range(1) == 1) t = t & 32'hFFFF_FFFC;
      o   = ($urandom_range(3) == 0) ? 32'($urandom) : 32'($urandom_range(256)) - 32'd128;
      drive_cycle($sformatf("rnd%0d", n), r, s, sel, t, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
